// File: rtl/sram_width_adapter_pkg.sv
// Shared state encoding and wait-count limits for the SRAM width adapter.
package sram_width_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int WAIT_CYCLES_MAX = 15;
    localparam int WAIT_CNT_W      = $clog2(WAIT_CYCLES_MAX + 1);

endpackage

// File: rtl/sram_wait_timer.sv
// Strobe wait counter: loads in SETUP, counts down through ACCESS, flags the last cycle.
module sram_wait_timer
    import sram_width_adapter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [WAIT_CNT_W-1:0] i_load_val,
    output logic                  o_done
);

    logic [WAIT_CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/sram_width_adapter.sv
// Host-word to narrow asynchronous SRAM adapter issuing R = host/sram beats per request.
// Optional build macro SRAM_WIDTH_ADAPTER_BEAT_SKIP_EN skips write beats with no byte enables.
module sram_width_adapter
    import sram_width_adapter_pkg::*;
#(
    parameter int HOST_DATA_WIDTH = 32,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH      = 20,
    parameter int WAIT_CYCLES     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [HOST_DATA_WIDTH-1:0]   req_wdata,
    input  logic [HOST_DATA_WIDTH/8-1:0] req_be,
    output logic                         rsp_valid,
    output logic [HOST_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                         sram_ce_n,
    output logic                         sram_we_n,
    output logic                         sram_oe_n,
    output logic                         sram_ub_n,
    output logic                         sram_lb_n,
    output logic [ADDR_WIDTH-1:0]        sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0]   sram_rd_data
);

    localparam int R          = HOST_DATA_WIDTH / SRAM_DATA_WIDTH;
    localparam int BEAT_SHIFT = $clog2(R);
    localparam int BEAT_W     = (R > 1) ? BEAT_SHIFT : 1;
    localparam int HOST_BE_W  = HOST_DATA_WIDTH / 8;
    localparam int SLICE_BE_W = SRAM_DATA_WIDTH / 8;

`ifdef SRAM_WIDTH_ADAPTER_BEAT_SKIP_EN
    localparam bit BEAT_SKIP = 1'b1;
`else
    localparam bit BEAT_SKIP = 1'b0;
`endif

    // Lowest beat >= start that must be issued; MSB of the result is the found flag.
    function automatic logic [BEAT_W:0] find_beat(input logic we, input logic [HOST_BE_W-1:0] be,
                                                  input int start);
        logic [BEAT_W:0] res;
        res = '0;
        for (int b = R - 1; b >= 0; b--) begin
            if (b >= start && (!we || !BEAT_SKIP || be[b*SLICE_BE_W +: SLICE_BE_W] != '0)) begin
                res = {1'b1, BEAT_W'(b)};
            end
        end
        return res;
    endfunction

    state_e                       r_state;
    logic [BEAT_W-1:0]            r_beat;
    logic                         r_we;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic [HOST_DATA_WIDTH-1:0]   r_wdata;
    logic [HOST_BE_W-1:0]         r_be;
    logic [HOST_DATA_WIDTH-1:0]   r_rd_buf;
    logic [HOST_DATA_WIDTH-1:0]   r_rdata;

    state_e                       w_next_state;
    logic [BEAT_W-1:0]            w_next_beat;
    logic                         w_accept;
    logic                         w_timer_load;
    logic                         w_timer_done;
    logic [BEAT_W:0]              w_find;
    logic [SLICE_BE_W-1:0]        w_slice_be;
    logic [HOST_DATA_WIDTH-1:0]   w_rd_merged;
    logic                         w_rd_capture;

    sram_wait_timer u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (WAIT_CNT_W'(WAIT_CYCLES - 1)),
        .o_done     (w_timer_done)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_beat  = r_beat;
        w_accept     = 1'b0;
        w_timer_load = 1'b0;
        w_find       = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_find       = find_beat(req_we, req_be, 0);
                    w_next_state = w_find[BEAT_W] ? ST_SETUP : ST_DONE;
                    w_next_beat  = w_find[BEAT_W-1:0];
                end
            end
            ST_SETUP: begin
                w_timer_load = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_timer_done) begin
                    w_find       = find_beat(r_we, r_be, int'(r_beat) + 1);
                    w_next_state = w_find[BEAT_W] ? ST_SETUP : ST_DONE;
                    if (w_find[BEAT_W]) begin
                        w_next_beat = w_find[BEAT_W-1:0];
                    end
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Read slices accumulate in r_rd_buf so rsp_rdata only changes when a read completes.
    always_comb begin
        w_rd_merged = r_rd_buf;
        w_rd_merged[int'(r_beat)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] = sram_rd_data;
    end

    assign w_rd_capture = (r_state == ST_ACCESS) && !r_we && w_timer_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_next_state;
            r_beat  <= w_next_beat;
        end
    end

    // NOTE: the datapath registers are plain flops, not memory, so all of them reset to a known value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rd_buf <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_rd_capture) begin
                r_rd_buf <= w_rd_merged;
                if (w_next_state == ST_DONE) begin
                    r_rdata <= w_rd_merged;
                end
            end
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = (r_state == ST_DONE);
    assign rsp_rdata    = r_rdata;
    assign sram_addr    = (r_addr << BEAT_SHIFT) | ADDR_WIDTH'(r_beat);
    assign sram_wr_data = r_wdata[int'(r_beat)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
    assign w_slice_be   = r_be[int'(r_beat)*SLICE_BE_W +: SLICE_BE_W];

    always_comb begin
        sram_ce_n = 1'b1;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_ub_n = 1'b1;
        sram_lb_n = 1'b1;
        if (r_state == ST_SETUP || r_state == ST_ACCESS) begin
            sram_ce_n = 1'b0;
            sram_lb_n = r_we ? ~w_slice_be[0] : 1'b0;
            if (SRAM_DATA_WIDTH == 16) begin
                sram_ub_n = r_we ? ~w_slice_be[SLICE_BE_W-1] : 1'b0;
            end
            if (r_state == ST_ACCESS) begin
                sram_we_n = ~r_we;
                sram_oe_n = r_we;
            end
        end
    end

endmodule

// File: doc/sram_width_adapter.md
SRAM_WIDTH_ADAPTER -- requirements
Module: sram_width_adapter

Interface
REQ-001 SHALL have parameter HOST_DATA_WIDTH, default 32: host word width; an integer multiple of SRAM_DATA_WIDTH.
REQ-002 SHALL have parameter SRAM_DATA_WIDTH, default 16: SRAM bus width; legal values are 8 and 16 only.
REQ-003 SHALL have parameter ADDR_WIDTH, default 20: width of the SRAM half-word/byte address.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, range 1..15: number of active strobe cycles per beat.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; port list, clock and reset first:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  adapter can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  host word address
req_wdata  in  HOST_DATA_WIDTH  write data
req_be  in  HOST_DATA_WIDTH/8  byte enables, active high
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  HOST_DATA_WIDTH  read data; valid with rsp_valid
sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wr_data  out  SRAM_DATA_WIDTH  SRAM write data
sram_rd_data  in  SRAM_DATA_WIDTH  SRAM read data

Function
REQ-006 SHALL define R = HOST_DATA_WIDTH/SRAM_DATA_WIDTH; R is a power of two; each request SHALL issue exactly R beats, beat 0 carrying the least-significant slice.
REQ-007 SHALL accept a request on a clk edge where req_valid && req_ready, capturing we, addr, wdata and be; req_ready SHALL be 1 only in IDLE.
REQ-008 SHALL drive sram_addr = (req_addr*R + beat) modulo 2^ADDR_WIDTH, so the address wraps silently at the top.
REQ-009 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> (SETUP if beat < R-1, else DONE) -> IDLE.
REQ-010 In SETUP (1 cycle), SHALL drive ce_n=0, we_n=1, oe_n=1 and hold address and data stable.
REQ-011 In ACCESS (WAIT_CYCLES cycles), SHALL drive ce_n=0; writes drive we_n=0, reads drive oe_n=0; reads capture sram_rd_data into the beat slot on the last ACCESS cycle.
REQ-012 SHALL drive ub_n/lb_n per beat as the inverted byte enables of that slice on writes and 0 on reads; for SRAM_DATA_WIDTH=8, ub_n SHALL be held at 1.
REQ-013 In DONE, SHALL assert rsp_valid for exactly 1 cycle for both reads and writes; rsp_rdata SHALL hold its value until the next read completes.
REQ-014 Accept-to-rsp_valid latency SHALL be R*(1+WAIT_CYCLES)+1 cycles when no beat is skipped.
REQ-015 A req_valid arriving while busy SHALL be ignored, not queued; the host must hold it until accepted.
REQ-016 Outside SETUP and ACCESS, all SRAM strobes SHALL be 1.

Reset
REQ-017 While rst=1, SHALL hold: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, all strobes 1, sram_addr=0, sram_wr_data=0.
REQ-018 Reset asserted mid-transaction SHALL abort it immediately; no rsp_valid SHALL follow.

Configuration
REQ-019 With SRAM_WIDTH_ADAPTER_BEAT_SKIP_EN defined, SHALL skip write beats whose slice byte enables are all zero (no SETUP/ACCESS for that beat); a write with req_be=0 SHALL go straight to DONE.
REQ-020 Without SRAM_WIDTH_ADAPTER_BEAT_SKIP_EN, SHALL issue every beat, with ub_n/lb_n=1 on beats whose byte enables are all zero; reads are never skipped in either build.

Structure
REQ-021 SHALL place the FSM state enum and the WAIT_CYCLES limit constant in the shared package sram_width_adapter_pkg.
REQ-022 SHALL implement the strobe wait counter as sub-module sram_wait_timer (load, count down, done flag); beat indexing and data muxing stay in the top.

Verification
REQ-023 Default parameters, write addr=0x00010, wdata=0xDEADBEEF, be=0xF -> sram_addr 0x00020 with data 0xBEEF, then 0x00021 with 0xDEAD; rsp_valid 5 cycles after accept.
REQ-024 Read back addr=0x00010 -> rsp_rdata=0xDEADBEEF; oe_n low for exactly 1 cycle per beat.
REQ-025 Write be=0xC, BEAT_SKIP_EN defined -> only beat 1 issued, latency 3; without the macro -> beat 0 issued with ub_n=lb_n=1, latency 5.
REQ-026 SRAM_DATA_WIDTH=8, WAIT_CYCLES=3, addr=0xFFFFF -> 4 beats at 0xFFFFC..0xFFFFF, ub_n always 1, latency 17.
REQ-027 rst pulsed during ACCESS of beat 0 -> strobes go to 1 asynchronously, no rsp_valid, next request completes normally.
